ifu_bpu_ctrl: RTL and testbench

Static branch-predict controller in the IFU, fed by the mini-decoder's bjp/jal/jalr/imm outputs. It predicts taken/not-taken and produces the two next-PC adder operands. For JALR it sequences rs1 acquisition: it waits out register hazards, then arbitrates for the regfile read port it shares with the EXU. It stalls the IFU through a valid/ready handshake until the operands are complete.

---
 rtl/ifu_bpu_ctrl_if.sv | 53 +++++
 rtl/ifu_bpu_ctrl.sv | 133 +++++++++++++
 tb/tb_ifu_bpu_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_bpu_ctrl_if.sv
// Bundle between the IFU mini-decoder, the branch-predict controller and the shared regfile read port.
// The controller attaches through the slave modport; the fetch/regfile side uses master.
interface ifu_bpu_ctrl_if #(
    parameter int XLEN        = 32,
    parameter int PC_SIZE     = 32,
    parameter int RFIDX_WIDTH = 5
);
    logic                   ifu_flush;

    logic                   dec_i_valid;
    logic                   dec_i_ready;
    logic [PC_SIZE-1:0]     pc;
    logic                   dec_bjp;
    logic                   dec_jal;
    logic                   dec_jalr;
    logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx;
    logic [XLEN-1:0]        dec_bjp_imm;

    logic                   oitf_empty;
    logic                   ir_valid_rdwen;
    logic [RFIDX_WIDTH-1:0] ir_rdidx;

    logic [XLEN-1:0]        rf2bpu_x1;
    logic                   bpu2rf_rs1_req;
    logic [RFIDX_WIDTH-1:0] bpu2rf_rs1_idx;
    logic                   rf2bpu_rs1_gnt;
    logic [XLEN-1:0]        rf2bpu_rs1;

    logic                   prdt_valid;
    logic                   prdt_taken;
    logic [PC_SIZE-1:0]     prdt_pc_add_op1;
    logic [PC_SIZE-1:0]     prdt_pc_add_op2;

    modport slave (
        input  ifu_flush,
        input  dec_i_valid, pc, dec_bjp, dec_jal, dec_jalr, dec_jalr_rs1idx, dec_bjp_imm,
        output dec_i_ready,
        input  oitf_empty, ir_valid_rdwen, ir_rdidx,
        input  rf2bpu_x1, rf2bpu_rs1_gnt, rf2bpu_rs1,
        output bpu2rf_rs1_req, bpu2rf_rs1_idx,
        output prdt_valid, prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2
    );

    modport master (
        output ifu_flush,
        output dec_i_valid, pc, dec_bjp, dec_jal, dec_jalr, dec_jalr_rs1idx, dec_bjp_imm,
        input  dec_i_ready,
        output oitf_empty, ir_valid_rdwen, ir_rdidx,
        output rf2bpu_x1, rf2bpu_rs1_gnt, rf2bpu_rs1,
        input  bpu2rf_rs1_req, bpu2rf_rs1_idx,
        input  prdt_valid, prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2
    );
endinterface

// File: rtl/ifu_bpu_ctrl.sv
// Static branch predictor for the IFU: predicts taken/not-taken, builds the next-PC adder
// operands and sequences the JALR rs1 fetch (hazard wait, then shared read-port arbitration).
module ifu_bpu_ctrl #(
    parameter int XLEN        = 32,
    parameter int PC_SIZE     = 32,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    ifu_bpu_ctrl_if.slave        bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DEP = 2'd1,
        REQ      = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] rs1_buf;

    logic rs1_is_x0;
    logic rs1_is_x1;
    logic jalr_xn;
    logic dep_x1;
    logic dep_xn;
    logic ready_raw;
    logic ready;
    logic fire;
    logic is_cond_branch;

    assign rs1_is_x0 = (bus.dec_jalr_rs1idx == RFIDX_WIDTH'(0));
    assign rs1_is_x1 = (bus.dec_jalr_rs1idx == RFIDX_WIDTH'(1));
    assign jalr_xn   = bus.dec_jalr & ~rs1_is_x0 & ~rs1_is_x1;

    // Any outstanding long-pipe write may target rs1, so it blocks both the x1 tap and the read port.
    assign dep_x1 = ~bus.oitf_empty | (bus.ir_valid_rdwen & (bus.ir_rdidx == RFIDX_WIDTH'(1)));
    assign dep_xn = ~bus.oitf_empty | (bus.ir_valid_rdwen & (bus.ir_rdidx == bus.dec_jalr_rs1idx));

    // Handshake: an instruction is consumed in a cycle where dec_i_valid & dec_i_ready are both high.
    // The decoder must hold dec_i_valid and every dec_* field stable while ready is low; only
    // ifu_flush may abandon a stalled instruction. Ready never depends on dec_i_valid.
    always_comb begin
        ready_raw = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.dec_jalr || rs1_is_x0) begin
                    ready_raw = 1'b1;
                end else if (rs1_is_x1) begin
                    ready_raw = ~dep_x1;
                end else begin
                    ready_raw = 1'b0;
                end
            end
            DONE:    ready_raw = 1'b1;
            default: ready_raw = 1'b0;
        endcase
    end

    assign ready           = ready_raw & ~bus.ifu_flush;
    assign bus.dec_i_ready = ready;

    // Prediction outputs stay quiet while reset is held, even though ready follows IDLE rules.
    assign fire           = bus.dec_i_valid & ready & rst;
    assign bus.prdt_valid = fire;

    assign is_cond_branch = bus.dec_bjp & ~bus.dec_jal & ~bus.dec_jalr;

    assign bus.prdt_taken = fire & (bus.dec_jal | bus.dec_jalr |
                                    (is_cond_branch & bus.dec_bjp_imm[XLEN-1]));

    always_comb begin
        bus.prdt_pc_add_op1 = '0;
        if (fire) begin
            if (bus.dec_jalr) begin
                if (rs1_is_x0) begin
                    bus.prdt_pc_add_op1 = '0;
                end else if (rs1_is_x1) begin
                    bus.prdt_pc_add_op1 = bus.rf2bpu_x1[PC_SIZE-1:0];
                end else begin
                    bus.prdt_pc_add_op1 = rs1_buf[PC_SIZE-1:0];
                end
            end else begin
                bus.prdt_pc_add_op1 = bus.pc;
            end
        end
    end

    assign bus.prdt_pc_add_op2 = fire ? bus.dec_bjp_imm[PC_SIZE-1:0] : '0;

    assign bus.bpu2rf_rs1_req = (state == REQ) & bus.dec_i_valid & ~bus.ifu_flush;
    assign bus.bpu2rf_rs1_idx = bus.dec_jalr_rs1idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rs1_buf <= '0;
        end else if (bus.ifu_flush || !bus.dec_i_valid) begin
            // rs1_buf deliberately survives an abort; it is rewritten before its next use.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (jalr_xn) begin
                        state <= dep_xn ? WAIT_DEP : REQ;
                    end
                end
                WAIT_DEP: begin
                    if (!dep_xn) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.rf2bpu_rs1_gnt) begin
                        rs1_buf <= bus.rf2bpu_rs1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_ifu_bpu_ctrl.sv
// Directed bench for ifu_bpu_ctrl: branch/jal/jalr prediction, JALR hazard and grant sequencing,
// flush and asynchronous reset aborts.
module tb_ifu_bpu_ctrl;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_DEP = 2'd1;
    localparam logic [1:0] S_REQ      = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         total;
    int         bad;

    ifu_bpu_ctrl_if bus ();

    ifu_bpu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ifu_flush       = 1'b0;
        bus.dec_i_valid     = 1'b0;
        bus.pc              = '0;
        bus.dec_bjp         = 1'b0;
        bus.dec_jal         = 1'b0;
        bus.dec_jalr        = 1'b0;
        bus.dec_jalr_rs1idx = '0;
        bus.dec_bjp_imm     = '0;
        bus.oitf_empty      = 1'b1;
        bus.ir_valid_rdwen  = 1'b0;
        bus.ir_rdidx        = '0;
        bus.rf2bpu_x1       = '0;
        bus.rf2bpu_rs1_gnt  = 1'b0;
        bus.rf2bpu_rs1      = '0;
    endtask

    task automatic drive_branch(input logic [31:0] pc_v, input logic [31:0] imm);
        bus.dec_i_valid = 1'b1;
        bus.pc          = pc_v;
        bus.dec_bjp     = 1'b1;
        bus.dec_jal     = 1'b0;
        bus.dec_jalr    = 1'b0;
        bus.dec_bjp_imm = imm;
    endtask

    task automatic drive_jalr(input logic [4:0] idx, input logic [31:0] imm);
        bus.dec_i_valid     = 1'b1;
        bus.pc              = 32'h8000_0040;
        bus.dec_bjp         = 1'b1;
        bus.dec_jal         = 1'b0;
        bus.dec_jalr        = 1'b1;
        bus.dec_jalr_rs1idx = idx;
        bus.dec_bjp_imm     = imm;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #2;
        total++;
        if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
        total++;
        if (bus.bpu2rf_rs1_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus.bpu2rf_rs1_req); end
        total++;
        if ({bus.prdt_valid, bus.prdt_taken, bus.prdt_pc_add_op1, bus.prdt_pc_add_op2} !== 66'd0) begin
            bad++; $display("FAIL reset_prdt: valid=%b taken=%b op1=%h op2=%h want all 0",
                            bus.prdt_valid, bus.prdt_taken, bus.prdt_pc_add_op1, bus.prdt_pc_add_op2);
        end
        total++;
        if (bus.dec_i_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.dec_i_ready); end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_cond_branch();
        drive_branch(32'h8000_0010, 32'hFFFF_FFF0);
        #2;
        total++;
        if (bus.prdt_valid !== 1'b1 || bus.prdt_taken !== 1'b1) begin
            bad++; $display("FAIL beq_back: valid=%b taken=%b want 1 1", bus.prdt_valid, bus.prdt_taken);
        end
        total++;
        if (bus.prdt_pc_add_op1 !== 32'h8000_0010 || bus.prdt_pc_add_op2 !== 32'hFFFF_FFF0) begin
            bad++; $display("FAIL beq_back_ops: op1=%h op2=%h want 80000010 fffffff0",
                            bus.prdt_pc_add_op1, bus.prdt_pc_add_op2);
        end
        tick();
        drive_branch(32'h8000_0010, 32'h0000_0020);
        #2;
        total++;
        if (bus.prdt_valid !== 1'b1 || bus.prdt_taken !== 1'b0 || bus.prdt_pc_add_op2 !== 32'h20) begin
            bad++; $display("FAIL beq_fwd: valid=%b taken=%b op2=%h want 1 0 00000020",
                            bus.prdt_valid, bus.prdt_taken, bus.prdt_pc_add_op2);
        end
        tick();
        // Non-branch with a negative immediate must not predict taken.
        drive_branch(32'h8000_0014, 32'hFFFF_FF00);
        bus.dec_bjp = 1'b0;
        #2;
        total++;
        if (bus.prdt_valid !== 1'b1 || bus.prdt_taken !== 1'b0) begin
            bad++; $display("FAIL non_bjp: valid=%b taken=%b want 1 0", bus.prdt_valid, bus.prdt_taken);
        end
        tick();
        idle_inputs();
        #2;
        total++;
        if (bus.prdt_valid !== 1'b0 || bus.prdt_pc_add_op1 !== 32'h0 || bus.prdt_pc_add_op2 !== 32'h0) begin
            bad++; $display("FAIL gated_ops: valid=%b op1=%h op2=%h want 0 0 0",
                            bus.prdt_valid, bus.prdt_pc_add_op1, bus.prdt_pc_add_op2);
        end
        tick();
    endtask

    task automatic test_jal_jalr_x0();
        drive_branch(32'h8000_0020, 32'h0000_0100);
        bus.dec_jal = 1'b1;
        #2;
        total++;
        if (bus.prdt_valid !== 1'b1 || bus.prdt_taken !== 1'b1 ||
            bus.prdt_pc_add_op1 !== 32'h8000_0020 || bus.prdt_pc_add_op2 !== 32'h100) begin
            bad++; $display("FAIL jal: valid=%b taken=%b op1=%h op2=%h want 1 1 80000020 00000100",
                            bus.prdt_valid, bus.prdt_taken, bus.prdt_pc_add_op1, bus.prdt_pc_add_op2);
        end
        tick();
        drive_jalr(5'd0, 32'h8);
        #2;
        total++;
        if (bus.prdt_valid !== 1'b1 || bus.prdt_taken !== 1'b1 ||
            bus.prdt_pc_add_op1 !== 32'h0 || bus.prdt_pc_add_op2 !== 32'h8) begin
            bad++; $display("FAIL jalr_x0: valid=%b taken=%b op1=%h op2=%h want 1 1 00000000 00000008",
                            bus.prdt_valid, bus.prdt_taken, bus.prdt_pc_add_op1, bus.prdt_pc_add_op2);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_jalr_x1();
        drive_jalr(5'd1, 32'h4);
        bus.rf2bpu_x1  = 32'h8000_0400;
        bus.oitf_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++;
            if (bus.dec_i_ready !== 1'b0 || bus.prdt_valid !== 1'b0 || dbg_state !== S_IDLE) begin
                bad++; $display("FAIL jalr_x1_stall[%0d]: ready=%b valid=%b state=%0d want 0 0 0",
                                i, bus.dec_i_ready, bus.prdt_valid, dbg_state);
            end
            tick();
        end
        bus.oitf_empty = 1'b1;
        #2;
        total++;
        if (bus.prdt_valid !== 1'b1 || bus.prdt_taken !== 1'b1 ||
            bus.prdt_pc_add_op1 !== 32'h8000_0400 || bus.prdt_pc_add_op2 !== 32'h4) begin
            bad++; $display("FAIL jalr_x1_accept: valid=%b taken=%b op1=%h op2=%h want 1 1 80000400 00000004",
                            bus.prdt_valid, bus.prdt_taken, bus.prdt_pc_add_op1, bus.prdt_pc_add_op2);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_jalr_xn_grant();
        int req_cycles;
        req_cycles = 0;
        drive_jalr(5'd5, 32'h10);
        bus.rf2bpu_rs1 = 32'h1234;
        #2;
        total++;
        if (bus.dec_i_ready !== 1'b0 || bus.bpu2rf_rs1_req !== 1'b0 || dbg_state !== S_IDLE) begin
            bad++; $display("FAIL xn_first: ready=%b req=%b state=%0d want 0 0 0",
                            bus.dec_i_ready, bus.bpu2rf_rs1_req, dbg_state);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.rf2bpu_rs1_gnt = (i == 2);
            #2;
            if (bus.bpu2rf_rs1_req === 1'b1) req_cycles++;
            total++;
            if (bus.bpu2rf_rs1_req !== 1'b1 || bus.bpu2rf_rs1_idx !== 5'd5 || bus.dec_i_ready !== 1'b0) begin
                bad++; $display("FAIL xn_req[%0d]: req=%b idx=%0d ready=%b want 1 5 0",
                                i, bus.bpu2rf_rs1_req, bus.bpu2rf_rs1_idx, bus.dec_i_ready);
            end
            tick();
        end
        bus.rf2bpu_rs1_gnt = 1'b0;
        bus.rf2bpu_rs1     = 32'hDEAD_BEEF;
        #2;
        total++;
        if (req_cycles !== 3) begin bad++; $display("FAIL xn_req_count: got %0d want 3", req_cycles); end
        total++;
        if (dbg_state !== S_DONE || bus.bpu2rf_rs1_req !== 1'b0 || bus.prdt_valid !== 1'b1 ||
            bus.prdt_pc_add_op1 !== 32'h1234 || bus.prdt_pc_add_op2 !== 32'h10 || bus.prdt_taken !== 1'b1) begin
            bad++; $display("FAIL xn_done: state=%0d req=%b valid=%b taken=%b op1=%h op2=%h want 3 0 1 1 00001234 00000010",
                            dbg_state, bus.bpu2rf_rs1_req, bus.prdt_valid, bus.prdt_taken,
                            bus.prdt_pc_add_op1, bus.prdt_pc_add_op2);
        end
        tick();
        idle_inputs();
        #2;
        total++;
        if (dbg_state !== S_IDLE || bus.bpu2rf_rs1_req !== 1'b0) begin
            bad++; $display("FAIL xn_after: state=%0d req=%b want 0 0", dbg_state, bus.bpu2rf_rs1_req);
        end
        tick();
    endtask

    task automatic test_wait_dep();
        drive_jalr(5'd7, 32'h0);
        bus.ir_valid_rdwen = 1'b1;
        bus.ir_rdidx       = 5'd7;
        bus.rf2bpu_rs1     = 32'h55AA;
        tick();
        #2;
        total++;
        if (dbg_state !== S_WAIT_DEP || bus.bpu2rf_rs1_req !== 1'b0) begin
            bad++; $display("FAIL dep_wait1: state=%0d req=%b want 1 0", dbg_state, bus.bpu2rf_rs1_req);
        end
        tick();
        bus.ir_valid_rdwen = 1'b0;
        #2;
        total++;
        if (dbg_state !== S_WAIT_DEP || bus.bpu2rf_rs1_req !== 1'b0 || bus.dec_i_ready !== 1'b0) begin
            bad++; $display("FAIL dep_wait2: state=%0d req=%b ready=%b want 1 0 0",
                            dbg_state, bus.bpu2rf_rs1_req, bus.dec_i_ready);
        end
        tick();
        bus.rf2bpu_rs1_gnt = 1'b1;
        #2;
        total++;
        if (dbg_state !== S_REQ || bus.bpu2rf_rs1_req !== 1'b1 || bus.bpu2rf_rs1_idx !== 5'd7) begin
            bad++; $display("FAIL dep_req: state=%0d req=%b idx=%0d want 2 1 7",
                            dbg_state, bus.bpu2rf_rs1_req, bus.bpu2rf_rs1_idx);
        end
        tick();
        bus.rf2bpu_rs1_gnt = 1'b0;
        #2;
        total++;
        if (bus.prdt_valid !== 1'b1 || bus.prdt_pc_add_op1 !== 32'h55AA) begin
            bad++; $display("FAIL dep_done: valid=%b op1=%h want 1 000055aa", bus.prdt_valid, bus.prdt_pc_add_op1);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        // Minimum JALR-xn path: valid seen in cycle 0, accepted in cycle 2, next instruction right after.
        drive_jalr(5'd9, 32'h20);
        bus.rf2bpu_rs1_gnt = 1'b1;
        bus.rf2bpu_rs1     = 32'hCAFE_0000;
        #2;
        total++;
        if (bus.prdt_valid !== 1'b0) begin bad++; $display("FAIL b2b_c0: valid=%b want 0", bus.prdt_valid); end
        tick();
        #2;
        total++;
        if (bus.prdt_valid !== 1'b0 || bus.bpu2rf_rs1_req !== 1'b1) begin
            bad++; $display("FAIL b2b_c1: valid=%b req=%b want 0 1", bus.prdt_valid, bus.bpu2rf_rs1_req);
        end
        tick();
        #2;
        total++;
        if (bus.prdt_valid !== 1'b1 || bus.prdt_pc_add_op1 !== 32'hCAFE_0000) begin
            bad++; $display("FAIL b2b_c2: valid=%b op1=%h want 1 cafe0000", bus.prdt_valid, bus.prdt_pc_add_op1);
        end
        tick();
        idle_inputs();
        drive_branch(32'h8000_0080, 32'hFFFF_FFFC);
        #2;
        total++;
        if (bus.prdt_valid !== 1'b1 || bus.prdt_taken !== 1'b1 || bus.prdt_pc_add_op1 !== 32'h8000_0080) begin
            bad++; $display("FAIL b2b_next: valid=%b taken=%b op1=%h want 1 1 80000080",
                            bus.prdt_valid, bus.prdt_taken, bus.prdt_pc_add_op1);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        drive_jalr(5'd6, 32'h0);
        tick();
        #2;
        total++;
        if (bus.bpu2rf_rs1_req !== 1'b1) begin bad++; $display("FAIL flush_pre: req=%b want 1", bus.bpu2rf_rs1_req); end
        tick();
        bus.ifu_flush = 1'b1;
        #2;
        total++;
        if (bus.bpu2rf_rs1_req !== 1'b0 || bus.dec_i_ready !== 1'b0 || bus.prdt_valid !== 1'b0) begin
            bad++; $display("FAIL flush_cycle: req=%b ready=%b valid=%b want 0 0 0",
                            bus.bpu2rf_rs1_req, bus.dec_i_ready, bus.prdt_valid);
        end
        tick();
        idle_inputs();
        #2;
        total++;
        if (dbg_state !== S_IDLE) begin bad++; $display("FAIL flush_idle: state=%0d want 0", dbg_state); end
        tick();
        drive_branch(32'h8000_0100, 32'hFFFF_FF00);
        #2;
        total++;
        if (bus.prdt_valid !== 1'b1 || bus.prdt_taken !== 1'b1 || bus.prdt_pc_add_op1 !== 32'h8000_0100) begin
            bad++; $display("FAIL flush_bne: valid=%b taken=%b op1=%h want 1 1 80000100",
                            bus.prdt_valid, bus.prdt_taken, bus.prdt_pc_add_op1);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        drive_jalr(5'd7, 32'h0);
        bus.oitf_empty = 1'b0;
        tick();
        #2;
        total++;
        if (dbg_state !== S_WAIT_DEP) begin bad++; $display("FAIL rst_pre: state=%0d want 1", dbg_state); end
        rst = 1'b0;
        #1;
        total++;
        if (dbg_state !== S_IDLE || bus.bpu2rf_rs1_req !== 1'b0 || bus.prdt_valid !== 1'b0) begin
            bad++; $display("FAIL rst_async: state=%0d req=%b valid=%b want 0 0 0",
                            dbg_state, bus.bpu2rf_rs1_req, bus.prdt_valid);
        end
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        drive_branch(32'h8000_0200, 32'h0000_0040);
        #2;
        total++;
        if (bus.prdt_valid !== 1'b1 || bus.prdt_taken !== 1'b0 ||
            bus.prdt_pc_add_op1 !== 32'h8000_0200 || bus.prdt_pc_add_op2 !== 32'h40) begin
            bad++; $display("FAIL rst_bne: valid=%b taken=%b op1=%h op2=%h want 1 0 80000200 00000040",
                            bus.prdt_valid, bus.prdt_taken, bus.prdt_pc_add_op1, bus.prdt_pc_add_op2);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_cond_branch();
        test_jal_jalr_x0();
        test_jalr_x1();
        test_jalr_xn_grant();
        test_wait_dep();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
